// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: stall/flush/freeze control for hazards that EX-stage
// forwarding cannot resolve (load-use, taken branch, data-memory wait),
// plus saturating stall and flush counters.
module hazard_stall_unit #(
    parameter int REG_W          = 4,
    parameter int LOAD_STALL_CYC = 1,
    parameter int FLUSH_CYC      = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_wr,
    input  logic             ex_is_load,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_freeze,
    output logic [1:0]       state,
    output logic [15:0]      stall_cycles,
    output logic [7:0]       flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    localparam int MAXC  = (LOAD_STALL_CYC > FLUSH_CYC) ? LOAD_STALL_CYC : FLUSH_CYC;
    localparam int CNT_W = $clog2(MAXC + 1);

    state_t           cur, nxt, ret_q, ret_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu_hazard, mem_miss, flush_evt;

    // r0 is hardwired zero, so a load targeting it never creates a dependency
    assign lu_hazard = ex_is_load && ex_wr && (ex_rd != '0) &&
                       ((id_rs1_used && (id_rs1 == ex_rd)) ||
                        (id_rs2_used && (id_rs2 == ex_rd)));
    assign mem_miss  = dmem_req && !dmem_ready;
    assign state     = cur;

    // Next state and zero-latency controls; a memory miss always wins, and
    // the interrupted state plus its countdown are parked until memory is ready
    always_comb begin
        nxt          = cur;
        cnt_d        = cnt_q;
        ret_d        = ret_q;
        flush_evt    = 1'b0;
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_freeze  = 1'b0;
        case (cur)
            RUN: begin
                if (mem_miss) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    pipe_freeze = 1'b1;
                    ret_d       = RUN;
                    nxt         = MEM_WAIT;
                end else if (branch_taken) begin
                    // ID instruction is on the wrong path, so its hazard is moot
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    flush_evt    = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        cnt_d = CNT_W'(FLUSH_CYC - 1);
                        nxt   = FLUSH;
                    end
                end else if (lu_hazard) begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_bubble = 1'b1;
                    if (LOAD_STALL_CYC > 1) begin
                        cnt_d = CNT_W'(LOAD_STALL_CYC - 1);
                        nxt   = LU_STALL;
                    end
                end
            end
            LU_STALL: begin
                if (mem_miss) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    pipe_freeze = 1'b1;
                    ret_d       = LU_STALL;
                    nxt         = MEM_WAIT;
                end else begin
                    pc_stall     = 1'b1;
                    if_id_stall  = 1'b1;
                    id_ex_bubble = 1'b1;
                    cnt_d        = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) nxt = RUN;
                end
            end
            FLUSH: begin
                // a branch seen here is a bubble's, so it is ignored
                if (mem_miss) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    pipe_freeze = 1'b1;
                    ret_d       = FLUSH;
                    nxt         = MEM_WAIT;
                end else begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    cnt_d        = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) nxt = RUN;
                end
            end
            MEM_WAIT: begin
                // EX is frozen, so branch/load hazards re-present after exit
                if (!dmem_ready) begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    pipe_freeze = 1'b1;
                end else begin
                    nxt = ret_q;
                end
            end
            default: nxt = RUN;
        endcase
        if (rst) begin
            pc_stall     = 1'b0;
            if_id_stall  = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_bubble = 1'b0;
            pipe_freeze  = 1'b0;
            flush_evt    = 1'b0;
        end
    end

    // State, countdown, return state and saturating counters
    always_ff @(posedge clk) begin
        if (rst) begin
            cur          <= RUN;
            cnt_q        <= '0;
            ret_q        <= RUN;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            cur   <= nxt;
            cnt_q <= cnt_d;
            ret_q <= ret_d;
            if (pc_stall && (stall_cycles != 16'hFFFF)) stall_cycles <= stall_cycles + 16'd1;
            if (flush_evt && (flush_count != 8'hFF))    flush_count  <= flush_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: two instances (LOAD=1/FLUSH=2 and LOAD=3/FLUSH=1)
// share stimulus and are compared every cycle against a pending-work model.
module tb_hazard_stall_unit;

    logic       clk = 1'b0, rst = 1'b1;
    logic [3:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_rs1_used = 0, id_rs2_used = 0, ex_wr = 0, ex_is_load = 0;
    logic       branch_taken = 0, dmem_req = 0, dmem_ready = 1;

    logic       pc_stall_a, if_id_stall_a, if_id_flush_a, id_ex_bubble_a, pipe_freeze_a;
    logic [1:0] state_a;
    logic [15:0] stall_cycles_a;
    logic [7:0] flush_count_a;
    logic       pc_stall_b, if_id_stall_b, if_id_flush_b, id_ex_bubble_b, pipe_freeze_b;
    logic [1:0] state_b;
    logic [15:0] stall_cycles_b;
    logic [7:0] flush_count_b;

    int checks = 0, errors = 0;

    // model: pending bubble/flush cycles, wait flag and event counts
    int lc [2] = '{1, 3};
    int fc [2] = '{2, 1};
    int m_sl [2] = '{0, 0};
    int m_fl [2] = '{0, 0};
    int m_sc [2] = '{0, 0};
    int m_fc [2] = '{0, 0};
    bit m_wait [2] = '{0, 0};
    logic [30:0] exp_a, exp_b;

    wire [30:0] obs_a = {pc_stall_a, if_id_stall_a, if_id_flush_a, id_ex_bubble_a,
                         pipe_freeze_a, state_a, stall_cycles_a, flush_count_a};
    wire [30:0] obs_b = {pc_stall_b, if_id_stall_b, if_id_flush_b, id_ex_bubble_b,
                         pipe_freeze_b, state_b, stall_cycles_b, flush_count_b};

    hazard_stall_unit #(.REG_W(4), .LOAD_STALL_CYC(1), .FLUSH_CYC(2)) dut_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
        .ex_wr(ex_wr), .ex_is_load(ex_is_load), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_stall(pc_stall_a),
        .if_id_stall(if_id_stall_a), .if_id_flush(if_id_flush_a),
        .id_ex_bubble(id_ex_bubble_a), .pipe_freeze(pipe_freeze_a), .state(state_a),
        .stall_cycles(stall_cycles_a), .flush_count(flush_count_a));

    hazard_stall_unit #(.REG_W(4), .LOAD_STALL_CYC(3), .FLUSH_CYC(1)) dut_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd),
        .ex_wr(ex_wr), .ex_is_load(ex_is_load), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .pc_stall(pc_stall_b),
        .if_id_stall(if_id_stall_b), .if_id_flush(if_id_flush_b),
        .id_ex_bubble(id_ex_bubble_b), .pipe_freeze(pipe_freeze_b), .state(state_b),
        .stall_cycles(stall_cycles_b), .flush_count(flush_count_b));

    always #5 clk = ~clk;

    // Expected outputs this cycle for instance k, then advance the model past the edge
    task automatic model(input int k, output logic [30:0] e);
        logic ps, is_, fl, bb, fz;
        logic [1:0] st;
        logic [15:0] sc0;
        logic [7:0] fc0;
        bit mm, lu;
        ps = 0; is_ = 0; fl = 0; bb = 0; fz = 0;
        mm = dmem_req && !dmem_ready;
        lu = ex_is_load && ex_wr && (ex_rd != 0) &&
             ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
        st  = m_wait[k] ? 2'd2 : (m_sl[k] > 0 ? 2'd1 : (m_fl[k] > 0 ? 2'd3 : 2'd0));
        sc0 = 16'(m_sc[k]);
        fc0 = 8'(m_fc[k]);
        if (rst) begin
            m_wait[k] = 0; m_sl[k] = 0; m_fl[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
        end else begin
            if (m_wait[k]) begin
                if (!dmem_ready) begin ps = 1; is_ = 1; fz = 1; end
                else m_wait[k] = 0;
            end else if (mm) begin
                ps = 1; is_ = 1; fz = 1; m_wait[k] = 1;
            end else if (m_sl[k] > 0) begin
                ps = 1; is_ = 1; bb = 1; m_sl[k]--;
            end else if (m_fl[k] > 0) begin
                fl = 1; bb = 1; m_fl[k]--;
            end else if (branch_taken) begin
                fl = 1; bb = 1; m_fl[k] = fc[k] - 1;
                if (m_fc[k] < 255) m_fc[k]++;
            end else if (lu) begin
                ps = 1; is_ = 1; bb = 1; m_sl[k] = lc[k] - 1;
            end
            if (ps && m_sc[k] < 65535) m_sc[k]++;
        end
        e = {ps, is_, fl, bb, fz, st, sc0, fc0};
    endtask

    task automatic cyc_model();
        model(0, exp_a);
        model(1, exp_b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_rs1_used = 0; id_rs2_used = 0;
        ex_wr = 0; ex_is_load = 0; branch_taken = 0; dmem_req = 0; dmem_ready = 1;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        @(negedge clk);
        cyc_model();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        tick();
        @(negedge clk);
        cyc_model();
        checks++;
        if (obs_a !== exp_a) begin errors++; $display("FAIL reset_a got %h want %h", obs_a, exp_a); end
        checks++;
        if (obs_b !== 31'h0) begin errors++; $display("FAIL reset_b got %h want %h", obs_b, 31'h0); end
        tick();
        rst = 0;
    endtask

    task automatic test_load_use();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            idle_inputs();
            if (c == 0) begin ex_is_load = 1; ex_wr = 1; ex_rd = 5; id_rs2 = 5; id_rs2_used = 1; end
            if (c == 2) begin ex_is_load = 1; ex_wr = 1; ex_rd = 0; id_rs2 = 0; id_rs2_used = 1; end
            @(negedge clk);
            cyc_model();
            checks++;
            if (obs_a !== exp_a) begin errors++; $display("FAIL load_use_a c%0d got %h want %h", c, obs_a, exp_a); end
            checks++;
            if (obs_b !== exp_b) begin errors++; $display("FAIL load_use_b c%0d got %h want %h", c, obs_b, exp_b); end
            if (c == 2) begin
                checks++;
                if (pc_stall_a !== 1'b0) begin errors++; $display("FAIL load_use_r0 pc_stall got %b want 0", pc_stall_a); end
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (stall_cycles_a !== 16'd1 || state_a !== 2'd0) begin
            errors++; $display("FAIL load_use_cnt got sc=%0d st=%0d want sc=1 st=0", stall_cycles_a, state_a);
        end
    endtask

    task automatic test_branch();
        int nflush;
        nflush = 0;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            idle_inputs();
            if (c == 0) begin
                branch_taken = 1; ex_is_load = 1; ex_wr = 1; ex_rd = 3; id_rs1 = 3; id_rs1_used = 1;
            end
            @(negedge clk);
            cyc_model();
            nflush += int'(if_id_flush_a);
            checks++;
            if (obs_a !== exp_a) begin errors++; $display("FAIL branch_a c%0d got %h want %h", c, obs_a, exp_a); end
            checks++;
            if (obs_b !== exp_b) begin errors++; $display("FAIL branch_b c%0d got %h want %h", c, obs_b, exp_b); end
            if (c == 1) begin
                checks++;
                if (state_a !== 2'd3) begin errors++; $display("FAIL branch_state got %0d want 3", state_a); end
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (nflush != 2 || flush_count_a !== 8'd1 || stall_cycles_a !== 16'd0) begin
            errors++;
            $display("FAIL branch_len got flush=%0d fc=%0d sc=%0d want 2 1 0", nflush, flush_count_a, stall_cycles_a);
        end
    endtask

    task automatic test_mem_wait();
        int nfreeze;
        nfreeze = 0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            idle_inputs();
            if (c < 4) begin dmem_req = 1; dmem_ready = (c == 3); end
            @(negedge clk);
            cyc_model();
            nfreeze += int'(pipe_freeze_a);
            checks++;
            if (obs_a !== exp_a) begin errors++; $display("FAIL mem_wait_a c%0d got %h want %h", c, obs_a, exp_a); end
            checks++;
            if (obs_b !== exp_b) begin errors++; $display("FAIL mem_wait_b c%0d got %h want %h", c, obs_b, exp_b); end
            tick();
        end
        @(negedge clk);
        checks++;
        if (nfreeze != 3 || stall_cycles_a !== 16'd3 || state_a !== 2'd0) begin
            errors++;
            $display("FAIL mem_wait_len got frz=%0d sc=%0d st=%0d want 3 3 0", nfreeze, stall_cycles_a, state_a);
        end
    endtask

    task automatic test_nested();
        int nbub;
        nbub = 0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            idle_inputs();
            if (c == 0) begin ex_is_load = 1; ex_wr = 1; ex_rd = 7; id_rs1 = 7; id_rs1_used = 1; end
            if (c >= 1 && c <= 3) begin dmem_req = 1; dmem_ready = (c == 3); end
            @(negedge clk);
            cyc_model();
            nbub += int'(id_ex_bubble_b);
            checks++;
            if (obs_a !== exp_a) begin errors++; $display("FAIL nested_a c%0d got %h want %h", c, obs_a, exp_a); end
            checks++;
            if (obs_b !== exp_b) begin errors++; $display("FAIL nested_b c%0d got %h want %h", c, obs_b, exp_b); end
            if (c == 4) begin
                checks++;
                if (state_b !== 2'd1) begin errors++; $display("FAIL nested_return got %0d want 1", state_b); end
            end
            tick();
        end
        checks++;
        if (nbub != 3) begin errors++; $display("FAIL nested_bubbles got %0d want 3", nbub); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst          = ($urandom_range(0, 79) == 0);
            id_rs1       = 4'($urandom_range(0, 3));
            id_rs2       = 4'($urandom_range(0, 3));
            ex_rd        = 4'($urandom_range(0, 3));
            id_rs1_used  = 1'($urandom);
            id_rs2_used  = 1'($urandom);
            ex_wr        = ($urandom_range(0, 3) != 0);
            ex_is_load   = 1'($urandom);
            branch_taken = ($urandom_range(0, 5) == 0);
            dmem_req     = ($urandom_range(0, 3) == 0);
            dmem_ready   = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            cyc_model();
            checks++;
            if (obs_a !== exp_a) begin errors++; $display("FAIL random_a c%0d got %h want %h", c, obs_a, exp_a); end
            checks++;
            if (obs_b !== exp_b) begin errors++; $display("FAIL random_b c%0d got %h want %h", c, obs_b, exp_b); end
            tick();
        end
        rst = 0;
    endtask

    task automatic test_saturate_reset();
        int bad;
        bad = 0;
        do_reset();
        idle_inputs();
        dmem_req = 1; dmem_ready = 0;
        for (int c = 0; c < 70000; c++) begin
            @(negedge clk);
            cyc_model();
            if (obs_a !== exp_a || obs_b !== exp_b) begin
                bad++;
                if (bad <= 3) $display("FAIL saturate c%0d got %h/%h want %h/%h", c, obs_a, obs_b, exp_a, exp_b);
            end
            tick();
        end
        checks++;
        if (bad != 0) errors++;
        @(negedge clk);
        checks++;
        if (stall_cycles_a !== 16'hFFFF || stall_cycles_b !== 16'hFFFF) begin
            errors++; $display("FAIL saturate_val got %h/%h want ffff", stall_cycles_a, stall_cycles_b);
        end
        tick();
        rst = 1;
        @(negedge clk);
        cyc_model();
        checks++;
        if (obs_a !== exp_a || {pc_stall_a, pipe_freeze_a, pc_stall_b} !== 3'b000) begin
            errors++; $display("FAIL rst_mid_wait got %h want %h", obs_a, exp_a);
        end
        tick();
        rst = 0;
        @(negedge clk);
        cyc_model();
        checks++;
        if (state_a !== 2'd0 || stall_cycles_a !== 16'd0 || flush_count_a !== 8'd0) begin
            errors++; $display("FAIL post_rst got st=%0d sc=%0d fc=%0d want 0 0 0", state_a, stall_cycles_a, flush_count_a);
        end
        checks++;
        if (obs_b !== exp_b) begin errors++; $display("FAIL post_rst_b got %h want %h", obs_b, exp_b); end
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_nested();
        test_random();
        test_saturate_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
